// File: rtl/add_seq_pkg.sv
// Shared types and constants for the sequential shared-adder arbiter.
// Chunk width is fixed by the adder16 slice.
package add_seq_pkg;

    localparam int CHUNK_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int chunk_count(input int width);
        return width / CHUNK_W;
    endfunction

endpackage

// File: rtl/add_seq_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr, wrapping modulo N. Emits a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W:0]   cand_sum [N];
    logic [IDX_W-1:0] cand_idx [N];
    logic [N-1:0]     cand_hit;

    // Candidate gi is the requester gi positions after the pointer.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, ptr} + (IDX_W + 1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (IDX_W + 1)'(N))
                                ? IDX_W'(cand_sum[gi] - (IDX_W + 1)'(N))
                                : cand_sum[gi][IDX_W-1:0];
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        grant       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                grant_idx   = cand_idx[i];
                grant_valid = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            grant[i] = grant_valid && (grant_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/adder16.sv
// 16-bit carry-lookahead adder slice: 4-bit lookahead groups with
// group generate/propagate feeding the next group's carry.
module adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [4:0]  gc;

    assign g     = a & b;
    assign p     = a ^ b;
    assign gc[0] = cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_group
            localparam int B = 4 * gi;
            assign c[B]     = gc[gi];
            assign c[B + 1] = g[B] | (p[B] & gc[gi]);
            assign c[B + 2] = g[B + 1] | (p[B + 1] & g[B]) | (p[B + 1] & p[B] & gc[gi]);
            assign c[B + 3] = g[B + 2] | (p[B + 2] & g[B + 1]) | (p[B + 2] & p[B + 1] & g[B])
                            | (p[B + 2] & p[B + 1] & p[B] & gc[gi]);
            assign gc[gi + 1] = g[B + 3] | (p[B + 3] & g[B + 2]) | (p[B + 3] & p[B + 2] & g[B + 1])
                              | (p[B + 3] & p[B + 2] & p[B + 1] & g[B])
                              | ((&p[B + 3:B]) & gc[gi]);
        end
    endgenerate

    assign sum  = p ^ c;
    assign cout = gc[4];

endmodule

// File: rtl/add_seq_arbiter.sv
// Round-robin shared adder: WIDTH-bit adds run as CHUNKS passes through one adder16.
// Optional signed-overflow output enabled by defining ADD_SEQ_ARBITER_OVERFLOW_EN.
module add_seq_arbiter
    import add_seq_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ-1:0]         req_cin,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [WIDTH-1:0]           resp_sum,
    output logic                       resp_carry
`ifdef ADD_SEQ_ARBITER_OVERFLOW_EN
    ,
    output logic                       resp_overflow
`endif
);

    localparam int CHUNKS = chunk_count(WIDTH);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]  chunk_reg, chunk_next;
    logic              carry_reg, carry_next;
    logic [WIDTH-1:0]  a_reg, a_next;
    logic [WIDTH-1:0]  b_reg, b_next;
    logic [WIDTH-1:0]  sum_reg, sum_next;
    logic [ID_W-1:0]   id_reg, id_next;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;

    logic [CHUNK_W-1:0] add_a;
    logic [CHUNK_W-1:0] add_b;
    logic [CHUNK_W-1:0] add_sum;
    logic               add_cout;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (rr_ptr_reg),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // carry_reg holds cin for chunk 0, so the adder always takes carry_reg.
    adder16 u_adder16 (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            if (chunk_reg == CNT_W'(i)) begin
                add_a = a_reg[i*CHUNK_W +: CHUNK_W];
                add_b = b_reg[i*CHUNK_W +: CHUNK_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            chunk_reg  <= '0;
            carry_reg  <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            sum_reg    <= '0;
            id_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            chunk_reg  <= chunk_next;
            carry_reg  <= carry_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            sum_reg    <= sum_next;
            id_reg     <= id_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        chunk_next  = chunk_reg;
        carry_next  = carry_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        sum_next    = sum_reg;
        id_next     = id_reg;
        req_ready   = '0;
        resp_valid  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    // Gated so no requester sees an accept while reset is held.
                    req_ready = grant & {NUM_REQ{rst_n}};
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant[i]) begin
                            a_next     = req_a[i*WIDTH +: WIDTH];
                            b_next     = req_b[i*WIDTH +: WIDTH];
                            carry_next = req_cin[i];
                        end
                    end
                    id_next     = grant_idx;
                    rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                    chunk_next  = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < CHUNKS; i++) begin
                    if (chunk_reg == CNT_W'(i)) begin
                        sum_next[i*CHUNK_W +: CHUNK_W] = add_sum;
                    end
                end
                carry_next = add_cout;
                if (chunk_reg == CNT_W'(CHUNKS - 1)) begin
                    state_next = DONE;
                end else begin
                    chunk_next = chunk_reg + CNT_W'(1);
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign resp_id    = id_reg;
    assign resp_sum   = sum_reg;
    assign resp_carry = carry_reg;

`ifdef ADD_SEQ_ARBITER_OVERFLOW_EN
    logic a_msb_reg;
    logic b_msb_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
        end else if (state_reg == IDLE && grant_valid) begin
            a_msb_reg <= a_next[WIDTH-1];
            b_msb_reg <= b_next[WIDTH-1];
        end
    end

    assign resp_overflow = (a_msb_reg == b_msb_reg) && (sum_reg[WIDTH-1] != a_msb_reg);
`endif

endmodule
